// File: rtl/mux7_rr_arbiter_pkg.sv
// mux7_pkg: shared constants, state encoding and small helpers for the 7-way
// round-robin arbiter that drives a 7:1 mux select.
//   N_REQ    - number of requesters / mux inputs
//   SEL_IDLE - select value when no grant is active
//   HOLD_W   - width of the consecutive-grant counter
//   state_t  - arbiter FSM state
package mux7_pkg;

    localparam int unsigned N_REQ    = 7;
    localparam logic [2:0]  SEL_IDLE = 3'd7;
    localparam int unsigned HOLD_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Round-robin successor, wrapping 6 -> 0.
    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'd6) ? 3'd0 : i + 3'd1;
    endfunction

    function automatic logic [N_REQ-1:0] onehot7(input logic [2:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/mux7_rr_arbiter_if.sv
// mux7_rr_arbiter_if: request/grant bundle between requesters and the arbiter.
//   req       - one request bit per source
//   gnt       - one-hot grant, zero when idle
//   sel       - binary mux select, SEL_IDLE when idle
//   sel_valid - grant active (equals |gnt)
// Modports: master = requester side, slave = arbiter side.
interface mux7_rr_arbiter_if;
    import mux7_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [2:0]       sel;
    logic             sel_valid;

    modport master (output req, input gnt, input sel, input sel_valid);
    modport slave  (input req, output gnt, output sel, output sel_valid);

endinterface

// File: rtl/mux7_rr_arbiter_pick.sv
// rr_pick7: combinational wrapping priority search over 7 requests.
//   req   - candidate request vector
//   ptr   - index searched first; search continues ptr+1, ... wrapping 6 -> 0
//   idx   - first set index found (0 when none)
//   found - at least one candidate bit set
module rr_pick7
    import mux7_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       idx,
    output logic             found
);

    logic [3:0] pos;

    always_comb begin
        idx   = 3'd0;
        found = 1'b0;
        pos   = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            // ptr <= 6 and i <= 6, so one subtraction is enough to wrap.
            pos = {1'b0, ptr} + 4'(i);
            if (pos >= 4'd7) begin
                pos = pos - 4'd7;
            end
            if (!found && req[pos[2:0]]) begin
                found = 1'b1;
                idx   = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/mux7_rr_arbiter.sv
// mux7_rr_arbiter: 7-way round-robin arbiter producing registered grant and
// mux-select outputs. A grant is held while its request stays high, but is
// rotated after MAX_HOLD consecutive cycles if anyone else is waiting.
//   MAX_HOLD - max consecutive grant cycles while another requester waits (2..15)
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   bus      - request/grant interface (slave modport)
// All outputs come straight from flops; req only reaches them through the FSM.
module mux7_rr_arbiter
    import mux7_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
)
(
    input  logic               clk,
    input  logic               rst_n,
    mux7_rr_arbiter_if.slave   bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [2:0]          sel_q;
    logic                valid_q;
    logic [2:0]          ptr_q;
    logic [HOLD_W-1:0]   hold_cnt_q;

    logic [N_REQ-1:0]    cand;
    logic                cur_held;
    logic [2:0]          pick_idx;
    logic                pick_found;

    // Excluding the current holder means "found" also answers
    // "is anyone else waiting?"; in IDLE gnt_q is zero so all of req counts.
    assign cand     = bus.req & ~gnt_q;
    assign cur_held = |(bus.req & gnt_q);

    rr_pick7 u_pick (
        .req   (cand),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= SEL_IDLE;
            valid_q    <= 1'b0;
            ptr_q      <= 3'd0;
            hold_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q    <= BUSY;
                        gnt_q      <= onehot7(pick_idx);
                        sel_q      <= pick_idx;
                        valid_q    <= 1'b1;
                        ptr_q      <= next_idx(pick_idx);
                        hold_cnt_q <= '0;
                    end
                end
                BUSY: begin
                    // Release takes priority over expiry; both hand over
                    // to the next waiter in the same edge.
                    if ((!cur_held || hold_cnt_q == HOLD_LAST) && pick_found) begin
                        gnt_q      <= onehot7(pick_idx);
                        sel_q      <= pick_idx;
                        ptr_q      <= next_idx(pick_idx);
                        hold_cnt_q <= '0;
                    end else if (!cur_held) begin
                        state_q    <= IDLE;
                        gnt_q      <= '0;
                        sel_q      <= SEL_IDLE;
                        valid_q    <= 1'b0;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        // Nobody else waiting: keep the grant, restart the count.
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    sel_q   <= SEL_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = valid_q;

endmodule

// File: tb/tb_mux7_rr_arbiter.sv
// tb_mux7_rr_arbiter: directed stimulus for mux7_rr_arbiter, checked every
// cycle against an integer-level round-robin model plus literal expectations.
module tb_mux7_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    mux7_rr_arbiter_if bus ();

    mux7_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cur = -1;  // granted index, -1 when idle
    int m_ptr = 0;   // first index to search
    int m_cnt = 0;   // cycles the current grant has been kept

    function automatic int first_from(input logic [6:0] r, input int start);
        for (int i = 0; i < 7; i++) begin
            if (r[(start + i) % 7]) return (start + i) % 7;
        end
        return -1;
    endfunction

    // Returns new grant index, -1 for idle, -2 to keep the current grant.
    function automatic int decide(input logic [6:0] r, input int cur, input int ptr,
                                  input int cnt);
        logic [6:0] others;
        if (cur < 0) return first_from(r, ptr);
        others = r;
        others[cur] = 1'b0;
        if (!r[cur]) return first_from(others, ptr);
        if (cnt == MAX_HOLD - 1 && others != 7'd0) return first_from(others, ptr);
        return -2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur <= -1;
            m_ptr <= 0;
            m_cnt <= 0;
        end else begin
            m_cur <= (decide(bus.req, m_cur, m_ptr, m_cnt) == -2) ? m_cur
                     : decide(bus.req, m_cur, m_ptr, m_cnt);
            m_ptr <= (decide(bus.req, m_cur, m_ptr, m_cnt) >= 0)
                     ? (decide(bus.req, m_cur, m_ptr, m_cnt) + 1) % 7 : m_ptr;
            m_cnt <= (decide(bus.req, m_cur, m_ptr, m_cnt) == -2)
                     ? ((m_cnt == MAX_HOLD - 1) ? 0 : m_cnt + 1) : 0;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    logic [6:0] exp_gnt;
    logic [2:0] exp_sel;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_gnt = (m_cur < 0) ? 7'd0 : (7'd1 << m_cur);
            exp_sel = (m_cur < 0) ? 3'd7 : 3'(m_cur);
            check("model_gnt", 32'(bus.gnt), 32'(exp_gnt));
            check("model_sel", 32'(bus.sel), 32'(exp_sel));
            check("model_valid", 32'(bus.sel_valid), 32'(m_cur >= 0));
            check("consistent_valid", 32'(bus.sel_valid), 32'(|bus.gnt));
            if (bus.sel_valid) begin
                check("sel_range", 32'(bus.sel < 3'd7), 32'd1);
                if (bus.sel < 3'd7) check("gnt_at_sel", 32'(bus.gnt[bus.sel]), 32'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick();
        rst_n = 1'b0;
        bus.req = 7'd0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req = 7'd0;
        tick();
        tick();
        check("reset_gnt", 32'(bus.gnt), 32'd0);
        check("reset_sel", 32'(bus.sel), 32'd7);
        check("reset_valid", 32'(bus.sel_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_no_req_sel", 32'(bus.sel), 32'd7);

        // Single requester 0: one-cycle latency, then release to idle.
        bus.req = 7'b0000001;
        tick();
        check("single0_gnt", 32'(bus.gnt), 32'h01);
        check("single0_sel", 32'(bus.sel), 32'd0);
        check("single0_valid", 32'(bus.sel_valid), 32'd1);
        bus.req = 7'd0;
        tick();
        check("release_gnt", 32'(bus.gnt), 32'd0);
        check("release_sel", 32'(bus.sel), 32'd7);

        // Requesters 0 and 6: alternate every MAX_HOLD cycles, no gap.
        do_reset();
        bus.req = 7'b1000001;
        for (int c = 0; c < 32; c++) begin
            tick();
            check("alt06_sel", 32'(bus.sel), ((c / 8) % 2) ? 32'd6 : 32'd0);
            check("alt06_nogap", 32'(bus.sel_valid), 32'd1);
        end

        // All requesters: 0..6 then 0, each held MAX_HOLD cycles.
        do_reset();
        bus.req = 7'h7f;
        for (int c = 0; c < 64; c++) begin
            tick();
            check("all_sel", 32'(bus.sel), 32'((c / 8) % 7));
        end

        // Release handover 3 -> 5 -> 1 with zero bubble.
        do_reset();
        bus.req = 7'b0001000;
        tick();
        check("ho_first3", 32'(bus.sel), 32'd3);
        bus.req = 7'b0101010;
        tick();
        check("ho_keep3", 32'(bus.gnt), 32'h08);
        bus.req = 7'b0100010;
        tick();
        check("ho_to5", 32'(bus.sel), 32'd5);
        check("ho_to5_gnt", 32'(bus.gnt), 32'h20);
        bus.req = 7'b0000010;
        tick();
        check("ho_to1", 32'(bus.sel), 32'd1);
        check("ho_to1_valid", 32'(bus.sel_valid), 32'd1);

        // Lone requester 4 kept past MAX_HOLD.
        do_reset();
        bus.req = 7'b0010000;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("lone4_gnt", 32'(bus.gnt), 32'h10);
        end

        // Asynchronous reset mid-cycle during grant to 2, ptr returns to 0.
        do_reset();
        bus.req = 7'b0000100;
        tick();
        check("ar_grant2", 32'(bus.sel), 32'd2);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gnt_clear", 32'(bus.gnt), 32'd0);
        check("ar_sel_clear", 32'(bus.sel), 32'd7);
        check("ar_valid_clear", 32'(bus.sel_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        bus.req = 7'b0001100;
        tick();
        check("ar_post_sel", 32'(bus.sel), 32'd2);
        check("ar_post_gnt", 32'(bus.gnt), 32'h04);

        bus.req = 7'd0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux7_rr_arbiter.md
MUX7_RR_ARBITER -- requirements
Module: mux7_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles while another requester waits (legal range 2..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 req  input  7  request per source; bit k drives 7:1 mux data input k.
REQ-005 gnt  output  7  one-hot grant, all-zero when idle, registered.
REQ-006 sel  output  3  binary index of granted source for mux select, registered; 3'd7 when idle.
REQ-007 sel_valid  output  1  high when a grant is active, registered; equals |gnt.

Function
REQ-008 The FSM SHALL have two states: IDLE (no grant) and BUSY (one grant active).
REQ-009 IDLE: if req!=0, the next edge SHALL grant the first set bit searching ptr, ptr+1, ... wrapping 6->0, and enter BUSY; latency req->gnt = 1 cycle.
REQ-010 IDLE with req==0 SHALL hold gnt=0, sel=3'd7, sel_valid=0.
REQ-011 On every new grant to index k, ptr SHALL become k+1, wrapping 6->0.
REQ-012 BUSY: hold_cnt (4 bits) SHALL clear to 0 on each new grant and increment each cycle the grant is kept.
REQ-013 BUSY, req[cur] deasserted: if other requests are pending, the same edge SHALL grant the next one in round-robin order (zero bubble); otherwise return to IDLE.
REQ-014 BUSY, req[cur] high, hold_cnt==MAX_HOLD-1 and another request pending: the edge SHALL rotate grant to the next requester per REQ-009.
REQ-015 BUSY, hold_cnt==MAX_HOLD-1 with no other request: grant SHALL be kept and hold_cnt SHALL wrap to 0.
REQ-016 Simultaneous release of req[cur] and expiry SHALL behave as release (REQ-013).
REQ-017 Requests arriving in the same cycle SHALL be ordered purely by ptr; no requester may wait more than 6 grant periods.
REQ-018 gnt, sel and sel_valid SHALL always be mutually consistent: gnt[sel]==1 when sel_valid, gnt==0 when sel==3'd7.
REQ-019 sel SHALL never take a value other than 0..6 or 3'd7.

Reset
REQ-020 rst_n low SHALL immediately force gnt=0, sel=3'd7, sel_valid=0, ptr=0, hold_cnt=0, state IDLE, regardless of clk.
REQ-021 Reset asserted mid-grant SHALL drop the grant without completing rotation; after release the first grant follows REQ-009 from ptr=0.
REQ-022 The first rising edge after rst_n deasserts SHALL be a normal arbitration edge.

Structure
REQ-023 Package mux7_pkg SHALL hold N_REQ=7, SEL_IDLE=3'd7, the state encoding (IDLE=1'b0, BUSY=1'b1) and the hold_cnt width.
REQ-024 A combinational sub-module rr_pick7 (inputs req, ptr; outputs idx[2:0], found) SHALL implement the wrapping priority search; the top holds FSM, ptr, hold_cnt and output registers.
REQ-025 No combinational path SHALL exist from req to any output.

Verification
REQ-026 Reset then req=7'b0000001 held: gnt=7'b0000001, sel=0, sel_valid=1 one edge later; req=0 -> next edge gnt=0, sel=7.
REQ-027 req=7'b1000001 constant, MAX_HOLD=8: grants alternate index 0 (8 cycles) then 6 (8 cycles), repeating, no idle gap.
REQ-028 All 7 req high from reset: grant order 0,1,2,3,4,5,6,0 with each held exactly MAX_HOLD cycles.
REQ-029 Granted index 3, req[3] drops while req[5] and req[1] high: same edge grants 5, then 1 (wrap), gnt never zero between.
REQ-030 Single requester index 4 held 20 cycles, MAX_HOLD=8: gnt stays 7'b0010000 throughout, no release.
REQ-031 rst_n pulsed low mid-cycle during grant to 2: outputs clear before next clk edge; post-reset with req=7'b0001100 grants 2 first (ptr=0).
